// File: rtl/segasys1_hvgen_if.sv
// rtl/segasys1_hvgen_if.sv - sync offset inputs and video timing outputs of segasys1_hvgen
interface segasys1_hvgen_if;
    logic [3:0] HOFFS;
    logic [3:0] VOFFS;
    logic       PCLK_EN;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLANK;
    logic       VBLANK;
    logic       HSYNC;
    logic       VSYNC;
    logic       LINE_START;
    logic       FRAME_START;

    modport master (
        input  HOFFS, VOFFS,
        output PCLK_EN, PH, PV, HBLANK, VBLANK, HSYNC, VSYNC, LINE_START, FRAME_START
    );

    modport slave (
        output HOFFS, VOFFS,
        input  PCLK_EN, PH, PV, HBLANK, VBLANK, HSYNC, VSYNC, LINE_START, FRAME_START
    );
endinterface

// File: rtl/segasys1_hvgen.sv
// rtl/segasys1_hvgen.sv - Sega System 1 H/V video timing generator; HVGEN_SYNC_SHIFT_EN enables HOFFS/VOFFS sync shift
module segasys1_hvgen #(
    parameter int H_TOTAL  = 320,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 280,
    parameter int HS_WIDTH = 24,
    parameter int V_TOTAL  = 260,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 236,
    parameter int VS_LINES = 3
) (
    input  logic             VCLKx8,
    input  logic             RESET,
    segasys1_hvgen_if.master hv
);
    logic [2:0]  div_q, div_d;
    logic [8:0]  ph_q, ph_d, pv_q, pv_d;
    logic        hblank_q, hblank_d, vblank_q, vblank_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        line_start_q, line_start_d, frame_start_q, frame_start_d;

    logic        step;
    logic        ph_wrap, pv_wrap;
    logic [8:0]  ph_next, pv_next;
    logic [3:0]  hofs, vofs;
    logic [10:0] hs_lo, hs_hi, vs_lo, vs_hi;
    logic        in_hs, in_vs;

    // One pixel step every eighth VCLKx8 cycle; never during reset.
    assign step = (div_q == 3'd7) && !RESET;

`ifdef HVGEN_SYNC_SHIFT_EN
    logic [3:0] hofs_q, hofs_d, vofs_q, vofs_d;

    // Offsets are captured only on the frame wrap so a frame never sees a torn sync position.
    always_comb begin
        hofs_d = hofs_q;
        vofs_d = vofs_q;
        if (step && ph_wrap && pv_wrap) begin
            hofs_d = hv.HOFFS;
            vofs_d = hv.VOFFS;
        end
    end

    // Offset latch registers.
    always_ff @(posedge VCLKx8) begin
        if (RESET) begin
            hofs_q <= 4'd0;
            vofs_q <= 4'd0;
        end else begin
            hofs_q <= hofs_d;
            vofs_q <= vofs_d;
        end
    end

    assign hofs = hofs_q;
    assign vofs = vofs_q;
`else
    assign hofs = 4'd0;
    assign vofs = 4'd0;
`endif

    // Position the counters will hold after the current pixel step.
    always_comb begin
        ph_wrap = (ph_q == 9'(H_TOTAL - 1));
        pv_wrap = (pv_q == 9'(V_TOTAL - 1));
        ph_next = ph_wrap ? 9'd0 : ph_q + 9'd1;
        pv_next = pv_q;
        if (ph_wrap) begin
            pv_next = pv_wrap ? 9'd0 : pv_q + 9'd1;
        end
    end

    // Sync windows shifted by the signed offsets; parameters keep them inside the raster.
    always_comb begin
        hs_lo = 11'(HS_START) + {{7{hofs[3]}}, hofs};
        hs_hi = hs_lo + 11'(HS_WIDTH - 1);
        vs_lo = 11'(VS_START) + {{7{vofs[3]}}, vofs};
        vs_hi = vs_lo + 11'(VS_LINES - 1);
        in_hs = ({2'b00, ph_next} >= hs_lo) && ({2'b00, ph_next} <= hs_hi);
        in_vs = ({2'b00, pv_next} >= vs_lo) && ({2'b00, pv_next} <= vs_hi);
    end

    // Counter and timing-output next state; strobes last only the cycle after a step.
    always_comb begin
        div_d         = div_q + 3'd1;
        ph_d          = ph_q;
        pv_d          = pv_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (step) begin
            ph_d          = ph_next;
            pv_d          = pv_next;
            hblank_d      = (ph_next >= 9'(H_ACTIVE));
            vblank_d      = (pv_next >= V_ACTIVE[8:0]);
            hsync_d       = in_hs;
            if (in_hs && !hsync_q) begin
                vsync_d = in_vs;
            end
            line_start_d  = (ph_next == 9'd0);
            frame_start_d = (ph_next == 9'd0) && (pv_next == 9'd0);
        end
    end

    // Timing state registers.
    always_ff @(posedge VCLKx8) begin
        if (RESET) begin
            div_q         <= 3'd0;
            ph_q          <= 9'd0;
            pv_q          <= 9'd0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            ph_q          <= ph_d;
            pv_q          <= pv_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hv.PCLK_EN     = step;
    assign hv.PH          = ph_q;
    assign hv.PV          = pv_q;
    assign hv.HBLANK      = hblank_q;
    assign hv.VBLANK      = vblank_q;
    assign hv.HSYNC       = hsync_q;
    assign hv.VSYNC       = vsync_q;
    assign hv.LINE_START  = line_start_q;
    assign hv.FRAME_START = frame_start_q;
endmodule

// File: tb/tb_segasys1_hvgen.sv
// tb/tb_segasys1_hvgen.sv - testbench for segasys1_hvgen
module tb_segasys1_hvgen;
    localparam int H_TOTAL  = 32;
    localparam int H_ACTIVE = 20;
    localparam int HS_START = 20;
    localparam int HS_WIDTH = 4;
    localparam int V_TOTAL  = 24;
    localparam int V_ACTIVE = 16;
    localparam int VS_START = 12;
    localparam int VS_LINES = 3;
    localparam int FRAME_STEPS = H_TOTAL * V_TOTAL;

    typedef struct {
        int hs_lo;
        int hs_hi;
        int vs_lo;
        int vs_hi;
    } win_t;

    typedef struct {
        logic [3:0] hoffs;
        logic [3:0] voffs;
        int         hs_lo;
        int         hs_hi;
        int         vs_lo;
        int         vs_hi;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_big;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_step_cyc = -1;
    int   spacing_errs = 0;
    win_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    segasys1_hvgen_if sif ();
    segasys1_hvgen_if bif ();

    segasys1_hvgen #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_WIDTH(HS_WIDTH),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_LINES(VS_LINES)
    ) dut (
        .VCLKx8 (clk),
        .RESET  (rst),
        .hv     (sif)
    );

    segasys1_hvgen dut_big (
        .VCLKx8 (clk),
        .RESET  (rst_big),
        .hv     (bif)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance the small DUT by one pixel step, sampling 1ns after the stepping edge.
    task automatic step(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sif.PCLK_EN) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (last_step_cyc >= 0 && (cyc - last_step_cyc) != 8) spacing_errs++;
            last_step_cyc = cyc;
        end
    endtask

    task automatic run_to_wrap(output win_t w, output int steps, output int fs, output int errs);
        int pph, ppv, eph, epv;
        bit ok;
        w = '{999, -1, 999, -1};
        steps = 0;
        fs = 0;
        errs = 0;
        pph = int'(sif.PH);
        ppv = int'(sif.PV);
        for (int n = 0; n < FRAME_STEPS + 4; n++) begin
            step(ok);
            if (!ok) begin
                errs++;
                break;
            end
            steps++;
            eph = (pph == H_TOTAL - 1) ? 0 : pph + 1;
            epv = (pph == H_TOTAL - 1) ? ((ppv == V_TOTAL - 1) ? 0 : ppv + 1) : ppv;
            if (int'(sif.PH) != eph || int'(sif.PV) != epv) errs++;
            if (sif.HBLANK != (int'(sif.PH) >= H_ACTIVE)) errs++;
            if (sif.VBLANK != (int'(sif.PV) >= V_ACTIVE)) errs++;
            if (sif.LINE_START != (sif.PH == 9'd0)) errs++;
            if (sif.FRAME_START != (sif.PH == 9'd0 && sif.PV == 9'd0)) errs++;
            if (sif.FRAME_START) fs++;
            if (sif.HSYNC) begin
                if (int'(sif.PH) < w.hs_lo) w.hs_lo = int'(sif.PH);
                if (int'(sif.PH) > w.hs_hi) w.hs_hi = int'(sif.PH);
                if (sif.VSYNC) begin
                    if (int'(sif.PV) < w.vs_lo) w.vs_lo = int'(sif.PV);
                    if (int'(sif.PV) > w.vs_hi) w.vs_hi = int'(sif.PV);
                end
            end
            if (sif.PH == 9'd0 && sif.PV == 9'd0) break;
            pph = int'(sif.PH);
            ppv = int'(sif.PV);
        end
    endtask

    task automatic compare_win(input string tag, input win_t got);
        win_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hs_lo"}, got.hs_lo, e.hs_lo);
            check({tag, "_hs_hi"}, got.hs_hi, e.hs_hi);
            check({tag, "_vs_lo"}, got.vs_lo, e.vs_lo);
            check({tag, "_vs_hi"}, got.vs_hi, e.vs_hi);
        end
    endtask

    task automatic wait_pos(input int ph, input int pv);
        bit ok;
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME_STEPS; n++) begin
            if (int'(sif.PH) == ph && int'(sif.PV) == pv) begin
                found = 1'b1;
                break;
            end
            step(ok);
            if (!ok) break;
        end
        check($sformatf("reach_pos_%0d_%0d", ph, pv), int'(found), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        win_t base;
        win_t cur;
        win_t nxt;
        win_t got;
        int   steps, fs, errs, first;
        int   prev, wrap_from, pv_after, bhs_lo, bhs_hi, bhb_lo, bhb_hi;

`ifdef HVGEN_SYNC_SHIFT_EN
        vecs[0] = '{4'h8, 4'h7, 12, 15, 19, 21};
        vecs[1] = '{4'h7, 4'h8, 27, 30, 4, 6};
        vecs[2] = '{4'h3, 4'hF, 23, 26, 11, 13};
`else
        vecs[0] = '{4'h8, 4'h7, 20, 23, 12, 14};
        vecs[1] = '{4'h7, 4'h8, 20, 23, 12, 14};
        vecs[2] = '{4'h3, 4'hF, 20, 23, 12, 14};
`endif
        base = '{HS_START, HS_START + HS_WIDTH - 1, VS_START, VS_START + VS_LINES - 1};

        rst = 1'b1;
        rst_big = 1'b1;
        sif.HOFFS = 4'h0;
        sif.VOFFS = 4'h0;
        bif.HOFFS = 4'h0;
        bif.VOFFS = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ph", int'(sif.PH), 0);
        check("reset_pv", int'(sif.PV), 0);
        check("reset_pclk_en", int'(sif.PCLK_EN), 0);
        check("reset_flags", int'({sif.HBLANK, sif.VBLANK, sif.HSYNC, sif.VSYNC, sif.LINE_START, sif.FRAME_START}), 0);

        // First pixel step lands on the 8th edge after release.
        rst = 1'b0;
        rst_big = 1'b0;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (first == 0 && sif.PCLK_EN) first = k;
            @(posedge clk);
            #1;
            if (k == first) check("first_step_ph", int'(sif.PH), 1);
            @(negedge clk);
        end
        check("first_pclk_edge", first, 8);

        // Default-geometry line: HSYNC 280..303, HBLANK 256..319, wrap 319->0.
        prev = int'(bif.PH);
        wrap_from = -1;
        pv_after = -1;
        bhs_lo = 999; bhs_hi = -1; bhb_lo = 999; bhb_hi = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bif.PCLK_EN) begin
                @(posedge clk);
                #1;
                if (bif.PH == 9'd0) begin
                    wrap_from = prev;
                    pv_after = int'(bif.PV);
                    break;
                end
                if (bif.HSYNC) begin
                    if (int'(bif.PH) < bhs_lo) bhs_lo = int'(bif.PH);
                    if (int'(bif.PH) > bhs_hi) bhs_hi = int'(bif.PH);
                end
                if (bif.HBLANK) begin
                    if (int'(bif.PH) < bhb_lo) bhb_lo = int'(bif.PH);
                    if (int'(bif.PH) > bhb_hi) bhb_hi = int'(bif.PH);
                end
                prev = int'(bif.PH);
            end
        end
        check("big_wrap_from", wrap_from, 319);
        check("big_pv_after_wrap", pv_after, 1);
        check("big_hsync_lo", bhs_lo, 280);
        check("big_hsync_hi", bhs_hi, 303);
        check("big_hblank_lo", bhb_lo, 256);
        check("big_hblank_hi", bhb_hi, 319);

        // Clean restart of the small DUT, then one full frame with zero offsets.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_step_cyc = -1;
        exp_q.push_back(base);
        run_to_wrap(got, steps, fs, errs);
        compare_win("frame0", got);
        check("frame0_steps", steps, FRAME_STEPS);
        check("frame0_frame_start", fs, 1);
        check("frame0_track_errs", errs, 0);
        @(posedge clk);
        #1;
        check("frame_start_one_cycle", int'({sif.FRAME_START, sif.LINE_START}), 0);

        // Offsets written mid-frame: current frame unchanged, next frame shifted.
        cur = base;
        for (int i = 0; i < 3; i++) begin
            wait_pos(0, 3);
            sif.HOFFS = vecs[i].hoffs;
            sif.VOFFS = vecs[i].voffs;
            nxt = '{vecs[i].hs_lo, vecs[i].hs_hi, vecs[i].vs_lo, vecs[i].vs_hi};
            exp_q.push_back(cur);
            exp_q.push_back(nxt);
            run_to_wrap(got, steps, fs, errs);
            compare_win($sformatf("v%0d_same_frame", i), got);
            check($sformatf("v%0d_same_frame_errs", i), errs, 0);
            run_to_wrap(got, steps, fs, errs);
            compare_win($sformatf("v%0d_next_frame", i), got);
            check($sformatf("v%0d_next_steps", i), steps, FRAME_STEPS);
            check($sformatf("v%0d_next_errs", i), errs, 0);
            cur = nxt;
        end

        // Reset while inside both sync pulses: everything restarts, offsets drop to zero.
        wait_pos(24, 12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_step_cyc = -1;
        #1;
        check("midreset_ph", int'(sif.PH), 0);
        check("midreset_pv", int'(sif.PV), 0);
        check("midreset_sync", int'({sif.HSYNC, sif.VSYNC}), 0);
        exp_q.push_back(base);
        run_to_wrap(got, steps, fs, errs);
        compare_win("after_reset", got);
        check("after_reset_steps", steps, FRAME_STEPS);
        check("after_reset_errs", errs, 0);

        check("pclk_spacing_errs", spacing_errs, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/segasys1_hvgen.md
SEGASYS1_HVGEN -- requirements
Module: segasys1_hvgen

Interface
REQ-001 SHALL have parameter H_TOTAL, 320, pixels per line.
REQ-002 SHALL have parameter H_ACTIVE, 256, visible pixels per line.
REQ-003 SHALL have parameter HS_START, 280, nominal first HSYNC pixel.
REQ-004 SHALL have parameter HS_WIDTH, 24, HSYNC width in pixels.
REQ-005 SHALL have parameter V_TOTAL, 260, lines per frame.
REQ-006 SHALL have parameter V_ACTIVE, 224, visible lines.
REQ-007 SHALL have parameter VS_START, 236, nominal first VSYNC line.
REQ-008 SHALL have parameter VS_LINES, 3, VSYNC height in lines.
REQ-009 SHALL have port VCLKx8 input 1: the single clock, 8x pixel rate.
REQ-010 SHALL have port RESET input 1: reset, synchronous and active-high.
REQ-011 SHALL have port HOFFS input 4: signed horizontal sync shift, -8..+7 pixels.
REQ-012 SHALL have port VOFFS input 4: signed vertical sync shift, -8..+7 lines.
REQ-013 SHALL have port PCLK_EN output 1: pixel enable, one VCLKx8 cycle in 8.
REQ-014 SHALL have port PH output 9: horizontal pixel counter.
REQ-015 SHALL have port PV output 9: vertical line counter.
REQ-016 SHALL have ports HBLANK, VBLANK, HSYNC, VSYNC output 1 each, active-high.
REQ-017 SHALL have ports LINE_START, FRAME_START output 1 each: one-VCLKx8-cycle strobes.

Function
REQ-018 SHALL use a 3-bit free-running divider; PCLK_EN high only when divider==7 and RESET low.
REQ-019 SHALL update all counters and timing outputs only on VCLKx8 edges where PCLK_EN is high (a pixel step).
REQ-020 SHALL advance PH by 1 per pixel step; at PH==H_TOTAL-1, PH wraps to 0.
REQ-021 SHALL advance PV by 1 only on the PH wrap step; at PV==V_TOTAL-1, PV wraps to 0.
REQ-022 SHALL register HBLANK = (next PH >= H_ACTIVE) and VBLANK = (next PV >= V_ACTIVE), aligned with PH/PV.
REQ-023 SHALL assert HSYNC when PH is in [HS_START+hofs, HS_START+hofs+HS_WIDTH-1], hofs = latched sign-extended HOFFS, with no wrap-around.
REQ-024 SHALL update VSYNC only on the step where HSYNC rises: high if PV is in [VS_START+vofs, VS_START+vofs+VS_LINES-1], else low.
REQ-025 SHALL latch HOFFS/VOFFS into hofs/vofs only on the step where PH and PV both wrap to 0; mid-frame changes take effect next frame.
REQ-026 SHALL pulse LINE_START on the VCLKx8 cycle after any step making PH 0; FRAME_START likewise only when PV also becomes 0.
REQ-027 SHALL keep every sync window inside 0..H_TOTAL-1 / 0..V_TOTAL-1 for all offsets; parameter sets violating this are unsupported.

Reset
REQ-028 SHALL, while RESET high at a VCLKx8 edge, clear divider, PH, PV, hofs, vofs, HSYNC, VSYNC, LINE_START, FRAME_START to 0 and drive PCLK_EN 0.
REQ-029 SHALL set HBLANK=0 and VBLANK=0 at reset (position 0,0 is visible).
REQ-030 SHALL produce the first PCLK_EN 8 VCLKx8 cycles after RESET deasserts; reset mid-frame restarts at PH=0, PV=0 with no partial sync pulse.

Configuration
REQ-031 SHALL support macro HVGEN_SYNC_SHIFT_EN: defined, HOFFS/VOFFS operate per REQ-023..025; undefined, hofs/vofs tie to 0, HOFFS/VOFFS ignored and no latch registers exist.

Verification
REQ-032 SHALL check: RESET 1 then 0 -> PCLK_EN first high 8 cycles later, then every 8th cycle; PH 0->1 on that edge.
REQ-033 SHALL check: one full frame, offsets 0 -> PH wraps 319->0, PV wraps 259->0; 83200 PCLK_EN pulses per frame; FRAME_START once.
REQ-034 SHALL check: offsets 0 -> HSYNC high PH 280..303, HBLANK high PH 256..319, VBLANK high PV 224..259, VSYNC lines 236..238.
REQ-035 SHALL check: HOFFS=-8 (4'h8), VOFFS=+7 written at PV=100 -> unchanged this frame; next frame HSYNC PH 272..295, VSYNC lines 243..245.
REQ-036 SHALL check: RESET pulsed at PH=150, PV=120 -> next step PH=0, PV=0, HSYNC/VSYNC 0, hofs/vofs 0.
REQ-037 SHALL check: HVGEN_SYNC_SHIFT_EN undefined, HOFFS=7 -> HSYNC stays PH 280..303.
